avalon_bus_arbiter: RTL and testbench
=====================================

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

Interface
REQ-001 Parameter: none; all address/data widths fixed (address 32, data 32, byteenable 4).
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 i_address  input  32  instruction-fetch master address.
REQ-005 i_read  input  1  instruction-fetch read request; fetch master never writes.
REQ-006 i_waitrequest  output  1  stall to fetch master.
REQ-007 i_readdata  output  32  read data to fetch master.
REQ-008 d_address  input  32  data master address.
REQ-009 d_read  input  1  data master read request.
REQ-010 d_write  input  1  data master write request.
REQ-011 d_writedata  input  32  data master write data.
REQ-012 d_byteenable  input  4  data master byte lanes.
REQ-013 d_waitrequest  output  1  stall to data master.
REQ-014 d_readdata  output  32  read data to data master.
REQ-015 address, read, write, writedata, byteenable  output  32/1/1/32/4  shared Avalon master port to memory.
REQ-016 waitrequest  input  1, readdata  input  32  shared Avalon slave response.
REQ-017 protocol_err  output  1  sticky flag: d_read and d_write sampled high together.

Function
REQ-018 FSM states: IDLE, GRANT_I, GRANT_D; state register only.
REQ-019 IDLE: drive read=0, write=0, address=0, writedata=0, byteenable=0; i_waitrequest=1, d_waitrequest=1.
REQ-020 IDLE with exactly one requester pending (i_read, or d_read|d_write): next state grants that requester.
REQ-021 IDLE with both pending: round-robin; grant the master not granted last (last_grant register).
REQ-022 Arbitration latency: grant takes effect the cycle after the request is first seen in IDLE.
REQ-023 GRANT_x: shared port outputs equal granted master's inputs combinationally; fetch grant drives write=0, byteenable=4'b1111, writedata=0.
REQ-024 GRANT_x: granted master's waitrequest = bus waitrequest; other master's waitrequest = 1.
REQ-025 Transaction completes in the GRANT_x cycle where bus waitrequest=0; next state IDLE, last_grant updated to x.
REQ-026 GRANT_x with bus waitrequest=1: remain in GRANT_x; masters hold requests stable (Avalon rule); no preemption.
REQ-027 i_readdata and d_readdata both equal bus readdata at all times; valid only for the granted master at completion.
REQ-028 Requester deasserting its request while granted and waitrequest=1: return to IDLE next cycle, last_grant unchanged.
REQ-029 d_read and d_write both high in IDLE or GRANT_D: treated as write; protocol_err set to 1, held until reset.
REQ-030 Back-to-back: minimum one IDLE cycle between transactions; with both masters continuously requesting, grants alternate I, D, I, D.

Reset
REQ-031 Reset asserted (any cycle, including mid-transaction): state=IDLE immediately, read=0, write=0, all other shared outputs 0, i_waitrequest=1, d_waitrequest=1, protocol_err=0.
REQ-032 last_grant resets to D, so first contended grant after reset goes to fetch master.
REQ-033 Abandoned in-flight memory transaction on reset is not retried.

Structure
REQ-034 Shared package arb_pkg holds state enum (IDLE, GRANT_I, GRANT_D) and grant enum (GNT_I, GNT_D).
REQ-035 One sub-module arb_rr_pick: combinational next-grant selection from two requests and last_grant.
REQ-036 Top holds FSM, last_grant, protocol_err registers and output muxing.

Verification
REQ-037 Fetch only: i_read=1, i_address=32'hBFC0_0000, bus waitrequest low 2 cycles later -> read=1 with address BFC0_0000 from cycle 2; i_waitrequest falls with bus; i_readdata=bus readdata.
REQ-038 Contention after reset: i_read and d_write (d_address=32'h0000_1000, d_writedata=32'hDEAD_BEEF, byteenable=4'b0011) same cycle -> fetch granted first, write issued with exact data/byteenable after fetch completes.
REQ-039 Continuous both-request for 6 transactions, bus waitrequest always 0 -> grant order I,D,I,D,I,D, one IDLE cycle between each.
REQ-040 Bus waitrequest held 5 cycles during GRANT_D -> shared outputs stable, i_waitrequest=1 throughout, completion on cycle 6.
REQ-041 Reset asserted mid GRANT_D with waitrequest=1 -> read/write drop to 0 asynchronously, state IDLE, both waitrequests 1.
REQ-042 d_read=d_write=1 -> write=1, read=0 on bus, protocol_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and widths for the two-master Avalon bus arbiter.
package arb_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    // Arbiter control states; the state register is the only FSM storage.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_e;

    // Identity of a bus owner, used for the round-robin history.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin selector.
// Ports:
//   fetch_req_i   - fetch master is requesting
//   data_req_i    - data master is requesting
//   last_grant_i  - master that completed the most recent transaction
//   valid_o       - at least one request present
//   grant_o       - master to grant next (meaningful only when valid_o)
module arb_rr_pick
    import arb_pkg::*;
(
    input  logic   fetch_req_i,
    input  logic   data_req_i,
    input  grant_e last_grant_i,
    output logic   valid_o,
    output grant_e grant_o
);

    // Lone requester wins; on contention the master not served last wins.
    always_comb begin
        valid_o = fetch_req_i | data_req_i;
        grant_o = GNT_I;
        if (fetch_req_i && data_req_i) begin
            grant_o = (last_grant_i == GNT_D) ? GNT_I : GNT_D;
        end else if (data_req_i) begin
            grant_o = GNT_D;
        end
    end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Arbitrates an instruction-fetch master and a data master onto one shared
// Avalon memory port.
// Ports:
//   clk, reset                        - clock, async active-high reset
//   i_address/i_read                  - fetch master request (read only)
//   i_waitrequest/i_readdata          - fetch master response
//   d_address/d_read/d_write/
//   d_writedata/d_byteenable          - data master request
//   d_waitrequest/d_readdata          - data master response
//   address/read/write/writedata/
//   byteenable                        - shared port to memory
//   waitrequest/readdata              - memory response
//   protocol_err                      - sticky: data master read+write together
module avalon_bus_arbiter
    import arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] i_address,
    input  logic              i_read,
    output logic              i_waitrequest,
    output logic [DATA_W-1:0] i_readdata,

    input  logic [ADDR_W-1:0] d_address,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [DATA_W-1:0] d_writedata,
    input  logic [BE_W-1:0]   d_byteenable,
    output logic              d_waitrequest,
    output logic [DATA_W-1:0] d_readdata,

    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] writedata,
    output logic [BE_W-1:0]   byteenable,
    input  logic              waitrequest,
    input  logic [DATA_W-1:0] readdata,

    output logic              protocol_err
);

    state_e state_q, state_d;
    grant_e last_grant_q, last_grant_d;
    logic   perr_q, perr_d;

    logic   fetch_req;
    logic   data_req;
    logic   pick_valid;
    grant_e pick_grant;

    assign fetch_req = i_read;
    assign data_req  = d_read | d_write;

    arb_rr_pick u_pick (
        .fetch_req_i  (fetch_req),
        .data_req_i   (data_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .grant_o      (pick_grant)
    );

    // State, round-robin history and sticky error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_D;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            perr_q       <= perr_d;
        end
    end

    // Next-state logic and shared-port muxing.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        perr_d        = perr_q;
        address       = '0;
        read          = 1'b0;
        write         = 1'b0;
        writedata     = '0;
        byteenable    = '0;
        i_waitrequest = 1'b1;
        d_waitrequest = 1'b1;

        // Read+write together is only meaningful while the data master could own the bus.
        if ((state_q != GRANT_I) && d_read && d_write) begin
            perr_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = (pick_grant == GNT_I) ? GRANT_I : GRANT_D;
                end
            end

            GRANT_I: begin
                address       = i_address;
                read          = i_read;
                byteenable    = {BE_W{1'b1}};
                i_waitrequest = waitrequest;
                // A dropped request abandons the slot without counting as served.
                if (!fetch_req) begin
                    state_d = IDLE;
                end else if (!waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = GNT_I;
                end
            end

            GRANT_D: begin
                address       = d_address;
                write         = d_write;
                read          = d_read & ~d_write;
                writedata     = d_writedata;
                byteenable    = d_byteenable;
                d_waitrequest = waitrequest;
                if (!data_req) begin
                    state_d = IDLE;
                end else if (!waitrequest) begin
                    state_d      = IDLE;
                    last_grant_d = GNT_D;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign i_readdata   = readdata;
    assign d_readdata   = readdata;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed and randomized bench for avalon_bus_arbiter, checked against a
// bus-ownership reference model.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_address;
    logic        i_read;
    logic        i_waitrequest;
    logic [31:0] i_readdata;
    logic [31:0] d_address;
    logic        d_read;
    logic        d_write;
    logic [31:0] d_writedata;
    logic [3:0]  d_byteenable;
    logic        d_waitrequest;
    logic [31:0] d_readdata;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        protocol_err;

    always #5 clk = ~clk;

    avalon_bus_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .i_address     (i_address),
        .i_read        (i_read),
        .i_waitrequest (i_waitrequest),
        .i_readdata    (i_readdata),
        .d_address     (d_address),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_writedata   (d_writedata),
        .d_byteenable  (d_byteenable),
        .d_waitrequest (d_waitrequest),
        .d_readdata    (d_readdata),
        .address       (address),
        .read          (read),
        .write         (write),
        .writedata     (writedata),
        .byteenable    (byteenable),
        .waitrequest   (waitrequest),
        .readdata      (readdata),
        .protocol_err  (protocol_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data), who was served last, sticky error.
    int   m_owner = 0;
    int   m_last  = 2;
    logic m_perr  = 1'b0;

    // Per-cycle snapshot taken at the checking edge.
    int          g_obs;
    logic        s_read, s_write, s_iw, s_dw;
    logic [31:0] s_addr, s_wd;
    logic [3:0]  s_be;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        logic        e_rd, e_wr, e_iw, e_dw;
        e_addr = '0; e_wd = '0; e_be = '0;
        e_rd = 1'b0; e_wr = 1'b0; e_iw = 1'b1; e_dw = 1'b1;
        if (m_owner == 1) begin
            e_addr = i_address; e_rd = i_read; e_be = 4'hF; e_iw = waitrequest;
        end else if (m_owner == 2) begin
            e_addr = d_address; e_wr = d_write; e_rd = d_read && !d_write;
            e_wd = d_writedata; e_be = d_byteenable; e_dw = waitrequest;
        end
        chk({tag, ".address"},    address,          e_addr);
        chk({tag, ".read"},       32'(read),        32'(e_rd));
        chk({tag, ".write"},      32'(write),       32'(e_wr));
        chk({tag, ".writedata"},  writedata,        e_wd);
        chk({tag, ".byteenable"}, 32'(byteenable),  32'(e_be));
        chk({tag, ".i_wait"},     32'(i_waitrequest), 32'(e_iw));
        chk({tag, ".d_wait"},     32'(d_waitrequest), 32'(e_dw));
        chk({tag, ".i_rdata"},    i_readdata,       readdata);
        chk({tag, ".d_rdata"},    d_readdata,       readdata);
        chk({tag, ".perr"},       32'(protocol_err), 32'(m_perr));
    endtask

    // One clock: check at negedge, advance the model across the posedge, return at posedge+1.
    task automatic cyc(input string tag);
        int   n_owner, n_last;
        logic n_perr;
        bit   want_i, want_d;
        @(negedge clk);
        check_outputs(tag);
        g_obs   = (i_waitrequest == 1'b0) ? 1 : ((d_waitrequest == 1'b0) ? 2 : 0);
        s_read  = read;  s_write = write; s_iw = i_waitrequest; s_dw = d_waitrequest;
        s_addr  = address; s_wd = writedata; s_be = byteenable;
        n_owner = m_owner; n_last = m_last; n_perr = m_perr;
        if (!reset) begin
            want_i = i_read;
            want_d = d_read || d_write;
            if (m_owner != 1 && d_read && d_write) n_perr = 1'b1;
            if (m_owner == 0) begin
                if (want_i && want_d) n_owner = (m_last == 2) ? 1 : 2;
                else if (want_i)      n_owner = 1;
                else if (want_d)      n_owner = 2;
            end else begin
                if (!(m_owner == 1 ? want_i : want_d)) begin
                    n_owner = 0;
                end else if (!waitrequest) begin
                    n_owner = 0;
                    n_last  = m_owner;
                end
            end
        end
        @(posedge clk);
        m_owner = n_owner; m_last = n_last; m_perr = n_perr;
        #1;
    endtask

    task automatic idle_inputs();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_address = '0; d_address = '0; d_writedata = '0; d_byteenable = '0;
        waitrequest = 1'b0; readdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        m_owner = 0; m_last = 2; m_perr = 1'b0;
        cyc("reset");
        cyc("reset");
        reset = 1'b0;
    endtask

    initial begin
        int pat[12];
        int stall;
        reset = 1'b1;
        idle_inputs();
        do_reset();

        // Fetch-only read with a memory stall.
        i_read = 1'b1; i_address = 32'hBFC0_0000; waitrequest = 1'b1; readdata = 32'h1234_5678;
        cyc("fetch_idle");
        cyc("fetch_stall");
        chk("fetch_addr", s_addr, 32'hBFC0_0000);
        chk("fetch_read", 32'(s_read), 32'd1);
        waitrequest = 1'b0; readdata = 32'hCAFE_F00D;
        cyc("fetch_done");
        chk("fetch_grant", 32'(g_obs), 32'd1);
        i_read = 1'b0;
        cyc("fetch_after");

        // Contention right after reset: fetch first, then the write.
        do_reset();
        i_read = 1'b1; i_address = 32'h0000_0400;
        d_write = 1'b1; d_address = 32'h0000_1000; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        cyc("cont_idle");
        cyc("cont_first");
        chk("cont_first_gnt", 32'(g_obs), 32'd1);
        i_read = 1'b0;
        cyc("cont_gap");
        cyc("cont_second");
        chk("cont_second_gnt", 32'(g_obs), 32'd2);
        chk("cont_wr", 32'(s_write), 32'd1);
        chk("cont_waddr", s_addr, 32'h0000_1000);
        chk("cont_wdata", s_wd, 32'hDEAD_BEEF);
        chk("cont_be", 32'(s_be), 32'h3);
        d_write = 1'b0;
        cyc("cont_end");

        // Continuous contention: strict alternation with a gap cycle.
        do_reset();
        pat = '{0, 1, 0, 2, 0, 1, 0, 2, 0, 1, 0, 2};
        i_read = 1'b1; i_address = 32'h0000_0100;
        d_read = 1'b1; d_address = 32'h0000_2000;
        for (int k = 0; k < 12; k++) begin
            cyc("alt");
            chk($sformatf("alt_order[%0d]", k), 32'(g_obs), 32'(pat[k]));
        end
        idle_inputs();
        cyc("alt_end");

        // Data read stalled five cycles; fetch kept waiting throughout.
        d_read = 1'b1; d_address = 32'h0000_3000; waitrequest = 1'b1;
        i_read = 1'b0;
        cyc("stall_idle");
        stall = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin i_read = 1'b1; i_address = 32'h0000_0200; end
            cyc("stall");
            if (s_read && s_dw && s_iw && s_addr == 32'h0000_3000) stall++;
        end
        chk("stall_cycles", 32'(stall), 32'd5);
        waitrequest = 1'b0;
        cyc("stall_done");
        chk("stall_done_gnt", 32'(g_obs), 32'd2);
        d_read = 1'b0;
        cyc("stall_post");
        cyc("stall_post2");
        idle_inputs();
        cyc("stall_end");

        // Asynchronous reset in the middle of a stalled data write.
        d_write = 1'b1; d_address = 32'h0000_4000; d_writedata = 32'h0BAD_F00D;
        d_byteenable = 4'hF; waitrequest = 1'b1;
        cyc("ar_idle");
        cyc("ar_grant");
        chk("ar_pre_write", 32'(s_write), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_write", 32'(write), 32'd0);
        chk("ar_read", 32'(read), 32'd0);
        chk("ar_iwait", 32'(i_waitrequest), 32'd1);
        chk("ar_dwait", 32'(d_waitrequest), 32'd1);
        chk("ar_addr", address, 32'd0);
        m_owner = 0; m_last = 2; m_perr = 1'b0;
        cyc("ar_hold");
        reset = 1'b0;
        cyc("ar_release");
        idle_inputs();
        do_reset();

        // Read and write together: treated as write, sticky error.
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_5000; d_writedata = 32'h5555_AAAA;
        d_byteenable = 4'b1100;
        cyc("perr_idle");
        cyc("perr_grant");
        chk("perr_wr", 32'(s_write), 32'd1);
        chk("perr_rd", 32'(s_read), 32'd0);
        idle_inputs();
        for (int k = 0; k < 3; k++) cyc("perr_hold");
        chk("perr_sticky", 32'(protocol_err), 32'd1);
        do_reset();
        chk("perr_cleared", 32'(protocol_err), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            i_read       = ($urandom_range(0, 3) != 0);
            i_address    = $urandom;
            d_read       = ($urandom_range(0, 2) == 0);
            d_write      = ($urandom_range(0, 2) == 0) && ($urandom_range(0, 7) != 0 || d_read == 1'b0);
            d_address    = $urandom;
            d_writedata  = $urandom;
            d_byteenable = 4'($urandom);
            waitrequest  = ($urandom_range(0, 2) == 0);
            readdata     = $urandom;
            cyc("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
